// File: rtl/layer_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// layer_mem_arbiter_if
// Bundles the single shared layer-memory port.
//   master : arbiter side, drives the strobes, select, addresses and write data
//            and receives the read data.
//   slave  : memory side, the mirror image of master.
// Signals:
//   cwr       write strobe
//   crd       read strobe
//   csel      memory select (3'b000 = no memory)
//   caddr_wr  write word address
//   caddr_rd  read word address
//   cdata_wr  write data
//   cdata_rd  read data returned by the memory
// ---------------------------------------------------------------------------
interface layer_mem_arbiter_if;
   logic        cwr;
   logic        crd;
   logic [2:0]  csel;
   logic [11:0] caddr_wr;
   logic [11:0] caddr_rd;
   logic [19:0] cdata_wr;
   logic [19:0] cdata_rd;

   modport master (
      output cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr,
      input  cdata_rd
   );

   modport slave (
      input  cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr,
      output cdata_rd
   );
endinterface

// File: rtl/layer_mem_arbiter.sv
// ---------------------------------------------------------------------------
// layer_mem_arbiter
// Shares the layer-memory port among N requesters (0 = conv writer,
// 1 = max-pool, 2 = host readback) with round-robin arbitration and an
// optional burst lock. One registered memory beat is issued per cycle and read
// data is routed back to the requester that issued the read.
//
// Parameters:
//   N          number of requesters
//   RD_LAT     cycles from a crd beat until rdata/rvalid (1..3)
//   MAX_BURST  locked re-grants allowed while another requester waits
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   req        per-requester request
//   lock       per-requester burst hint
//   we         per-requester write (1) / read (0)
//   sel        per-requester memory select, packed 3 bits each
//   addr       per-requester word address, packed 12 bits each
//   wdata      per-requester write data, packed 20 bits each
//   gnt        one-hot, high in the cycle the requester's beat is on the port
//   rvalid     one-hot pulse marking rdata's owner
//   rdata      registered copy of the memory read data
//   busy       any request pending or any read in flight
//   mem        shared memory port (layer_mem_arbiter_if.master)
// Optional feature (macro LAYER_MEM_ARB_PERF_EN):
//   beat_cnt   saturating count of issued beats with a nonzero select
//   wait_max   longest saturating run of req=1/gnt=0 for any requester
// ---------------------------------------------------------------------------
module layer_mem_arbiter #(
   parameter int N         = 3,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req,
   input  logic [N-1:0]      lock,
   input  logic [N-1:0]      we,
   input  logic [3*N-1:0]    sel,
   input  logic [12*N-1:0]   addr,
   input  logic [20*N-1:0]   wdata,
   output logic [N-1:0]      gnt,
   output logic [N-1:0]      rvalid,
   output logic [19:0]       rdata,
   output logic              busy,
`ifdef LAYER_MEM_ARB_PERF_EN
   output logic [15:0]       beat_cnt,
   output logic [7:0]        wait_max,
`endif
   layer_mem_arbiter_if.master mem
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] last_idx;
   logic          last_valid;
   logic [CW-1:0] burst_cnt;

   logic          win_valid;
   logic          win_locked;
   logic [IW-1:0] win_idx;
   logic          others_req;
   logic [N-1:0]  last_mask;
   logic [IW:0]   cand_sum;
   logic [IW-1:0] cand;

   logic [2:0]    sel_w;
   logic          we_w;
   logic [11:0]   addr_w;
   logic [19:0]   wdata_w;
   logic          issue_rd;

   logic [RD_LAT-1:0] pipe_v;
   logic [IW-1:0]     pipe_id [RD_LAT];

   function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] idx);
      logic [N-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // Lock holder re-wins without search while under the burst limit; once the
   // limit is hit it keeps the port only if nobody else is waiting. Otherwise
   // search from rr_ptr and wrap; the loop runs backwards so the candidate
   // closest to rr_ptr is assigned last and wins.
   always_comb begin
      last_mask  = to_onehot(last_idx);
      others_req = |(req & ~last_mask);
      win_valid  = 1'b0;
      win_locked = 1'b0;
      win_idx    = '0;
      cand_sum   = '0;
      cand       = '0;
      if (last_valid && req[last_idx] && lock[last_idx] &&
          ((burst_cnt < CW'(MAX_BURST)) || !others_req)) begin
         win_valid  = 1'b1;
         win_locked = 1'b1;
         win_idx    = last_idx;
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(N)) cand_sum = cand_sum - (IW+1)'(N);
            cand = cand_sum[IW-1:0];
            if (req[cand]) begin
               win_valid = 1'b1;
               win_idx   = cand;
            end
         end
      end
   end

   // Pull the winner's beat fields out of the packed request buses.
   always_comb begin
      sel_w   = '0;
      we_w    = 1'b0;
      addr_w  = '0;
      wdata_w = '0;
      for (int i = 0; i < N; i++) begin
         if (win_idx == IW'(i)) begin
            sel_w   = sel[3*i +: 3];
            we_w    = we[i];
            addr_w  = addr[12*i +: 12];
            wdata_w = wdata[20*i +: 20];
         end
      end
   end

   // A select of 3'b000 consumes the grant but touches no memory.
   assign issue_rd = win_valid && !we_w && (sel_w != 3'b000);
   assign busy     = (|req) || (|pipe_v);

   // Register the winning beat onto the memory port; address/data outputs that
   // the beat does not use keep their previous values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt          <= '0;
         mem.cwr      <= 1'b0;
         mem.crd      <= 1'b0;
         mem.csel     <= 3'b000;
         mem.caddr_wr <= '0;
         mem.caddr_rd <= '0;
         mem.cdata_wr <= '0;
         rr_ptr       <= '0;
         last_idx     <= '0;
         last_valid   <= 1'b0;
         burst_cnt    <= '0;
      end else begin
         gnt     <= '0;
         mem.cwr <= 1'b0;
         mem.crd <= 1'b0;
         if (win_valid) begin
            gnt        <= to_onehot(win_idx);
            mem.csel   <= sel_w;
            last_idx   <= win_idx;
            last_valid <= 1'b1;
            rr_ptr     <= (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
            if (win_locked) begin
               if (burst_cnt < CW'(MAX_BURST)) burst_cnt <= burst_cnt + CW'(1);
            end else begin
               burst_cnt <= '0;
            end
            if (sel_w != 3'b000) begin
               if (we_w) begin
                  mem.cwr      <= 1'b1;
                  mem.caddr_wr <= addr_w;
                  mem.cdata_wr <= wdata_w;
               end else begin
                  mem.crd      <= 1'b1;
                  mem.caddr_rd <= addr_w;
               end
            end
         end
      end
   end

   // Owner ids travel alongside each read so returns stay in issue order; the
   // last stage captures cdata_rd and pulses the owner's rvalid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_v <= '0;
         for (int s = 0; s < RD_LAT; s++) pipe_id[s] <= '0;
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         pipe_v[0]  <= issue_rd;
         pipe_id[0] <= win_idx;
         for (int s = 1; s < RD_LAT; s++) begin
            pipe_v[s]  <= pipe_v[s-1];
            pipe_id[s] <= pipe_id[s-1];
         end
         rvalid <= '0;
         if (pipe_v[RD_LAT-1]) begin
            rvalid <= to_onehot(pipe_id[RD_LAT-1]);
            rdata  <= mem.cdata_rd;
         end
      end
   end

`ifdef LAYER_MEM_ARB_PERF_EN
   logic [7:0] wait_run [N];
   logic [7:0] wait_peak;

   always_comb begin
      wait_peak = wait_max;
      for (int i = 0; i < N; i++) begin
         if (wait_run[i] > wait_peak) wait_peak = wait_run[i];
      end
   end

   // Per-requester wait runs restart whenever the requester is granted or idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt <= '0;
         wait_max <= '0;
         for (int i = 0; i < N; i++) wait_run[i] <= '0;
      end else begin
         if (win_valid && (sel_w != 3'b000) && (beat_cnt != 16'hFFFF))
            beat_cnt <= beat_cnt + 16'd1;
         wait_max <= wait_peak;
         for (int i = 0; i < N; i++) begin
            if (req[i] && !gnt[i]) begin
               if (wait_run[i] != 8'hFF) wait_run[i] <= wait_run[i] + 8'd1;
            end else begin
               wait_run[i] <= '0;
            end
         end
      end
   end
`endif

endmodule
